spi_slave_port: RTL and testbench

- 16-bit SPI slave (responder), the far end of the board's SPI master links: mode 0 (CPOL=0, CPHA=0), MSB first.
- Lets this PLD act as an SPI target for an external master (supervisor MCU / test header).
- Exposes the same CPU register map and status semantics as the team's SPI master, so firmware drivers are shared.
- All SPI pins are oversampled in the clk domain; the block has no SCLK-domain logic.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_sync.sv | 26 ++
 rtl/spi_slave_port.sv | 117 +++++++++++
 tb/tb_spi_slave_port.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: register addresses, status/control bit positions and FSM states shared by the SPI slave
package spi_pkg;
   localparam logic [2:0] ADDR_RXDATA  = 3'd0;
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;
   localparam logic [2:0] ADDR_EOPVAL  = 3'd6;
   localparam int B_EOP  = 9;
   localparam int B_E    = 8;
   localparam int B_RRDY = 7;
   localparam int B_TRDY = 6;
   localparam int B_TMT  = 5;
   localparam int B_TOE  = 4;
   localparam int B_ROE  = 3;
   localparam int B_ABT  = 2;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARM   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: STAGES-deep synchronizer plus history flop giving rise/fall strobes
module spi_slave_sync #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] chain;
   logic hist;
   always_ff @(posedge clk)
      if (reset) begin
         chain <= {STAGES{INIT}};
         hist  <= INIT;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         hist  <= chain[STAGES-1];
      end
   assign q    = chain[STAGES-1];
   assign rise = q & ~hist;
   assign fall = ~q & hist;
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: mode-0 MSB-first SPI slave behind the shared SPI CPU register map; SPI_SLAVE_ABORT_STATUS_EN adds ABT status/irq bit 2
module spi_slave_port
   import spi_pkg::*;
#(
   parameter int          DATABITS      = 16,
   parameter logic [15:0] UNDERRUN_WORD = 16'h0000,
   parameter int          SYNC_STAGES   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_select,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   output logic        irq,
   output logic        dataavailable,
   output logic        readyfordata,
   output logic        endofpacket,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_oe
);
   localparam logic [4:0] LAST = 5'(DATABITS);
`ifdef SPI_SLAVE_ABORT_STATUS_EN
   localparam logic [15:0] CTRL_MASK = 16'h03DC;
`else
   localparam logic [15:0] CTRL_MASK = 16'h03D8;
`endif
   logic sclk_q, sclk_rise, sclk_fall, ss_q, ss_rise, ss_fall, mosi_q, mosi_rise, mosi_fall;
   logic [1:0] state;
   logic [DATABITS-1:0] shift_reg, tx_holding, rx_holding, eop_val, wdata, new_word, load_val;
   logic [4:0] bitcnt;
   logic [15:0] ctrl, status;
   logic rx_bit, primed, rrdy, roe, toe, eop, abt;
   logic rd_act, wr_act, rd_d, wr_d, rd_stb, wr_stb, rd_rx_q;
   logic wr_tx, wr_st, wr_ctl, wr_eopv, done, loading, unused;
   spi_slave_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk(clk), .reset(reset), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
   spi_slave_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
      .clk(clk), .reset(reset), .d(SS_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
   spi_slave_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
      .clk(clk), .reset(reset), .d(MOSI), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
   assign unused   = &{1'b0, sclk_q, mosi_rise, mosi_fall};
   assign rd_act   = spi_select & ~read_n;
   assign wr_act   = spi_select & ~write_n;
   assign rd_stb   = rd_act & ~rd_d;
   assign wr_stb   = wr_act & ~wr_d;
   assign wr_tx    = wr_stb & (mem_addr == ADDR_TXDATA);
   assign wr_st    = wr_stb & (mem_addr == ADDR_STATUS);
   assign wr_ctl   = wr_stb & (mem_addr == ADDR_CONTROL);
   assign wr_eopv  = wr_stb & (mem_addr == ADDR_EOPVAL);
   assign wdata    = data_from_cpu[DATABITS-1:0];
   assign new_word = {shift_reg[DATABITS-2:0], rx_bit};
   assign done     = (state == SHIFT) & sclk_fall & (bitcnt == LAST) & ~ss_rise;
   assign loading  = ~ss_rise & ((state == ARM) | done);
   // a tx write landing on the load cycle bypasses the holding register
   assign load_val = primed ? tx_holding : wr_tx ? wdata : UNDERRUN_WORD[DATABITS-1:0];
   assign status   = {6'b0, eop, toe | roe | abt, rrdy, ~primed, ~primed & (state == IDLE),
                      toe, roe, abt, 2'b0};
   assign dataavailable = rrdy;
   assign readyfordata  = ~primed;
   assign endofpacket   = eop;
   assign MISO_oe       = ~ss_q;
   assign MISO          = ~ss_q & shift_reg[DATABITS-1];
   always_ff @(posedge clk)
      if (reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         tx_holding  <= '0;
         rx_holding  <= '0;
         eop_val     <= '0;
         bitcnt      <= '0;
         ctrl        <= '0;
         rx_bit      <= 1'b0;
         primed      <= 1'b0;
         rrdy        <= 1'b0;
         roe         <= 1'b0;
         toe         <= 1'b0;
         eop         <= 1'b0;
         rd_d        <= 1'b0;
         wr_d        <= 1'b0;
         rd_rx_q     <= 1'b0;
         data_to_cpu <= '0;
         irq         <= 1'b0;
      end else begin
         rd_d    <= rd_act;
         wr_d    <= wr_act;
         rd_rx_q <= rd_stb & (mem_addr == ADDR_RXDATA);
         state   <= ss_rise ? IDLE : (state == IDLE && ss_fall) ? ARM : (state == ARM) ? SHIFT : state;
         bitcnt  <= (ss_rise | loading) ? 5'd0 : (state == SHIFT && sclk_rise) ? bitcnt + 5'd1 : bitcnt;
         if (state == SHIFT && sclk_rise) rx_bit <= mosi_q;
         shift_reg <= loading ? load_val : (state == SHIFT && sclk_fall) ? new_word : shift_reg;
         if (done) rx_holding <= new_word;
         rrdy   <= done | (rrdy & ~wr_st & ~rd_rx_q);
         roe    <= (done & rrdy) | (roe & ~wr_st);
         toe    <= (wr_tx & primed) | (toe & ~wr_st);
         eop    <= (wr_tx & (wdata == eop_val)) | (rd_rx_q & (rx_holding == eop_val)) | (eop & ~wr_st);
         primed <= (loading & primed) ? 1'b0 : (wr_tx & ~primed & ~loading) ? 1'b1 : primed;
         if (wr_tx & ~primed & ~loading) tx_holding <= wdata;
         if (wr_ctl) ctrl <= data_from_cpu & CTRL_MASK;
         if (wr_eopv) eop_val <= wdata;
         data_to_cpu <= (mem_addr == ADDR_STATUS) ? status : (mem_addr == ADDR_CONTROL) ? ctrl :
                        (mem_addr == ADDR_EOPVAL) ? 16'(eop_val) : 16'(rx_holding);
         irq <= |(status & ctrl);
      end
`ifdef SPI_SLAVE_ABORT_STATUS_EN
   always_ff @(posedge clk)
      if (reset) abt <= 1'b0;
      else abt <= (ss_rise & (bitcnt != 5'd0) & (bitcnt < LAST)) | (abt & ~wr_st);
`else
   assign abt = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed plus randomized frames checked against a flag-level model of the register map
module tb_spi_slave_port;
   logic clk = 1'b0;
   logic reset, spi_select, read_n, write_n, SCLK, SS_n, MOSI;
   logic [2:0] mem_addr;
   logic [15:0] data_from_cpu, data_to_cpu;
   logic irq, dataavailable, readyfordata, endofpacket, MISO, MISO_oe;
   int n_checks = 0, n_pass = 0;
   localparam logic [15:0] UNDER = 16'h0000;
`ifdef SPI_SLAVE_ABORT_STATUS_EN
   localparam logic [15:0] CMASK = 16'h03DC;
`else
   localparam logic [15:0] CMASK = 16'h03D8;
`endif
   logic m_primed, m_rrdy, m_roe, m_toe, m_eop, m_abt;
   logic [15:0] m_tx, m_rx, m_eopval, m_ctrl;
   always #15 clk = ~clk;
   spi_slave_port dut (
      .clk(clk), .reset(reset), .spi_select(spi_select), .mem_addr(mem_addr),
      .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
      .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
      .readyfordata(readyfordata), .endofpacket(endofpacket), .SCLK(SCLK),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe));
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask
   task automatic m_reset();
      {m_primed, m_rrdy, m_roe, m_toe, m_eop, m_abt} = '0;
      {m_tx, m_rx, m_eopval, m_ctrl} = '0;
   endtask
   function automatic logic [15:0] m_status();
      logic e;
      e = m_toe | m_roe | m_abt;
      return {6'b0, m_eop, e, m_rrdy, ~m_primed, ~m_primed, m_toe, m_roe, m_abt, 2'b0};
   endfunction
   function automatic logic m_irq();
      return (m_eop & m_ctrl[9]) | ((m_toe | m_roe | m_abt) & m_ctrl[8]) | (m_rrdy & m_ctrl[7]) |
             (~m_primed & m_ctrl[6]) | (m_toe & m_ctrl[4]) | (m_roe & m_ctrl[3]) | (m_abt & m_ctrl[2]);
   endfunction
   task automatic m_load(output logic [15:0] w);
      w = m_primed ? m_tx : UNDER;
      m_primed = 1'b0;
   endtask
   task automatic m_done(input logic [15:0] w);
      m_roe  = m_roe | m_rrdy;
      m_rrdy = 1'b1;
      m_rx   = w;
   endtask
   task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
      repeat (2) @(negedge clk);
      spi_select = 1'b0; write_n = 1'b1;
      @(negedge clk);
      case (a)
         3'd1: begin
            if (m_primed) m_toe = 1'b1;
            else begin m_tx = d; m_primed = 1'b1; end
            if (d == m_eopval) m_eop = 1'b1;
         end
         3'd2: {m_eop, m_rrdy, m_roe, m_toe, m_abt} = '0;
         3'd3: m_ctrl = d & CMASK;
         3'd6: m_eopval = d;
         default: ;
      endcase
   endtask
   task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
      @(negedge clk);
      d = data_to_cpu;
      @(negedge clk);
      spi_select = 1'b0; read_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic read_rx(input string tag);
      logic [15:0] d;
      cpu_read(3'd0, d);
      check(tag, d, m_rx);
      if (m_rx == m_eopval) m_eop = 1'b1;
      m_rrdy = 1'b0;
   endtask
   task automatic read_status(input string tag);
      logic [15:0] d;
      cpu_read(3'd2, d);
      check(tag, d, m_status());
   endtask
   task automatic ss_low();
      SS_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask
   task automatic ss_high();
      SS_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask
   task automatic spi_bits(input logic [15:0] w, input int n, output logic [15:0] got);
      got = '0;
      for (int i = 0; i < n; i++) begin
         MOSI = w[15-i];
         repeat (6) @(negedge clk);
         got = {got[14:0], MISO};
         SCLK = 1'b1;
         repeat (6) @(negedge clk);
         SCLK = 1'b0;
      end
      repeat (6) @(negedge clk);
   endtask
   task automatic do_frame(input int nw, input logic [15:0] w0, input logic [15:0] w1, input string tag);
      logic [15:0] exp, got;
      ss_low();
      m_load(exp);
      for (int k = 0; k < nw; k++) begin
         spi_bits(k == 0 ? w0 : w1, 16, got);
         check({tag, "_miso"}, got, exp);
         m_done(k == 0 ? w0 : w1);
         m_load(exp);
      end
      ss_high();
      check({tag, "_rrdy"}, 16'(dataavailable), 16'(m_rrdy));
   endtask
   task automatic do_reset(input string tag);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, "_data"}, data_to_cpu, 16'h0000);
      check({tag, "_irq"}, 16'(irq), 16'h0000);
      check({tag, "_rrdy"}, 16'(dataavailable), 16'h0000);
      check({tag, "_trdy"}, 16'(readyfordata), 16'h0001);
      check({tag, "_eop"}, 16'(endofpacket), 16'h0000);
      check({tag, "_miso"}, 16'(MISO), 16'h0000);
      check({tag, "_oe"}, 16'(MISO_oe), 16'h0000);
      reset = 1'b0;
      m_reset();
   endtask
   initial begin
      logic [15:0] a, b, got, exp, d;
      reset = 1'b1; spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1; mem_addr = 3'd0;
      data_from_cpu = '0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      do_reset("rst");
      repeat (4) @(negedge clk);
      read_status("rst_status");
      // primed word goes out while the master's word comes in
      cpu_write(3'd1, 16'hA55A);
      check("t1_trdy", 16'(readyfordata), 16'h0000);
      do_frame(1, 16'h3C96, 16'h0000, "t1");
      read_rx("t1_rx");
      check("t1_rrdy_clr", 16'(dataavailable), 16'h0000);
      read_status("t1_status");
      // back-to-back underrun words, second overruns
      a = 16'($urandom()); b = 16'($urandom());
      do_frame(2, a, b, "t2");
      read_status("t2_status");
      read_rx("t2_rx");
      cpu_write(3'd2, 16'hFFFF);
      // tx overrun leaves first word in the holding register
      a = 16'($urandom()); b = 16'($urandom());
      cpu_write(3'd1, a);
      cpu_write(3'd1, b);
      read_status("t3_toe");
      cpu_write(3'd2, 16'hFFFF);
      read_status("t3_clr");
      do_frame(1, 16'($urandom()), 16'h0000, "t3");
      read_rx("t3_rx");
      cpu_write(3'd2, 16'hFFFF);
      // end-of-packet match on rx read and irq enable
      cpu_write(3'd6, 16'h00FF);
      cpu_read(3'd6, d);
      check("t4_eopval", d, 16'h00FF);
      do_frame(1, 16'h00FF, 16'h0000, "t4");
      read_rx("t4_rx");
      check("t4_eop", 16'(endofpacket), 16'(m_eop));
      check("t4_irq_off", 16'(irq), 16'(m_irq()));
      cpu_write(3'd3, 16'h0200);
      check("t4_irq_on", 16'(irq), 16'(m_irq()));
      cpu_read(3'd3, d);
      check("t4_ctrl", d, m_ctrl);
      cpu_write(3'd3, 16'h0000);
      cpu_write(3'd2, 16'hFFFF);
      // deselect after 7 bits
      ss_low();
      m_load(exp);
      spi_bits(16'($urandom()), 7, got);
      ss_high();
`ifdef SPI_SLAVE_ABORT_STATUS_EN
      m_abt = 1'b1;
`endif
      check("t5_bits", 16'(got[6:0]), 16'(exp[15:9]));
      check("t5_rrdy", 16'(dataavailable), 16'h0000);
      read_status("t5_status");
      cpu_write(3'd2, 16'hFFFF);
      cpu_write(3'd1, 16'($urandom()));
      do_frame(1, 16'($urandom()), 16'h0000, "t5b");
      read_rx("t5b_rx");
      // reset mid-frame with SS_n held low
      cpu_write(3'd1, 16'($urandom()));
      ss_low();
      spi_bits(16'($urandom()), 9, got);
      do_reset("t6_rst");
      repeat (20) @(negedge clk);
      ss_high();
      read_status("t6_status");
      cpu_write(3'd6, 16'h00FF);
      cpu_write(3'd1, 16'($urandom()));
      do_frame(1, 16'($urandom()), 16'h0000, "t6");
      read_rx("t6_rx");
      for (int i = 0; i < 6; i++) begin
         cpu_write(3'd3, 16'($urandom()));
         if ($urandom_range(0, 1) == 1) cpu_write(3'd1, 16'($urandom()));
         do_frame(int'($urandom_range(1, 2)), 16'($urandom()), 16'($urandom()), "rnd");
         check("rnd_irq", 16'(irq), 16'(m_irq()));
         read_status("rnd_status");
         read_rx("rnd_rx");
         cpu_write(3'd2, 16'hFFFF);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
